systolic_output_collector: RTL and testbench
============================================

// Module: systolic_output_collector
// PURPOSE
//  Receiving end of the systolic array's bottom edge. Captures the column-staggered psum stream
//  (column j valid one cycle after column j-1, one word per column per result row). Re-aligns
//  each result row into a full SYS_DIM-wide vector and buffers it in a small row FIFO. Presents
//  each row downstream (accumulator/unified buffer) with a valid/ready handshake.
// PARAMETERS
//  SYS_DIM  16  array width = number of columns / psum lanes
//  PSUM_W   32  psum width per column
//  DEPTH    8   row FIFO depth in rows; power of two, >= 2
// PORTS
//  clk          in   1               clock; all logic rising-edge
//  rst          in   1               synchronous, active-high reset
//  col_psum     in   PSUM_W x SYS_DIM  array bottom-row psums, index = column
//  col_valid    in   1 x SYS_DIM       per-column valid from array bottom row
//  flush        in   1               synchronous clear of FIFO contents and pointers (not sticky flag)
//  row_data     out  PSUM_W x SYS_DIM  aligned result row at FIFO head
//  row_valid    out  1               head row complete in all columns
//  row_ready    in   1               downstream accepts row when row_valid && row_ready
//  row_count    out  $clog2(DEPTH)+1 number of complete rows buffered
//  overflow     out  1               sticky: a column word was dropped because its FIFO slot was full
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all wr_ptr[j], rd_ptr = 0; row_valid=0, row_count=0, overflow=0;
//    row_data = 0 (storage cleared). Reset mid-stream discards all partial and complete rows.
//  - Storage: DEPTH x SYS_DIM words; per-column write pointer wr_ptr[j] and one shared rd_ptr.
//    Pointers are $clog2(DEPTH)+1 bits (extra wrap bit); slot index = ptr[$clog2(DEPTH)-1:0].
//  - Column write: col_valid[j]=1 and occ[j] = wr_ptr[j]-rd_ptr < DEPTH -> mem[slot(wr_ptr[j])][j]
//    <= col_psum[j], wr_ptr[j]++. If occ[j]==DEPTH: word dropped, wr_ptr[j] held, overflow<=1.
//    Columns are independent; no assumption on stagger amount, only on per-column order.
//  - Row complete: occ[j] > 0 for every j. row_count = min over j of occ[j].
//    row_valid = (row_count != 0), registered view: a row whose last word is written at edge t
//    shows row_valid=1 from edge t (i.e. visible in cycle after the write). Write-to-valid latency = 1 clk.
//  - row_data = mem[slot(rd_ptr)] (read from storage, no extra register). Stable while row_valid && !row_ready.
//  - Pop: row_valid && row_ready at edge -> rd_ptr++, head row slot cleared to 0.
//    row_ready with row_valid=0 has no effect.
//  - Simultaneous pop and write to the slot being freed in the same edge: pop uses pre-edge
//    occ, so a column at occ==DEPTH still drops that cycle (no bypass). Write to another slot
//    and pop in same cycle both take effect.
//  - flush: same effect as rst on pointers/storage/row_valid, overflow unchanged; flush has
//    priority over same-cycle writes and pops (those are discarded).
//  - Wrap-around: pointer wrap bit distinguishes full vs empty; occ arithmetic modulo 2*DEPTH.
//  - overflow cleared only by rst.
// STRUCTURE
//  - tpu_pkg (shared): localparam SYS_DIM=16, PSUM_W=32; typedef logic [PSUM_W-1:0] psum_t;
//    typedef psum_t psum_row_t [SYS_DIM].
//  - One sub-module: collector_col_ptr (per column: wr_ptr, occ compute, accept/drop, overflow
//    contribution), generated SYS_DIM times; top holds storage, rd_ptr, min-reduction, handshake.
// TESTING
//  1 Reset: assert rst 2 clk with col_valid all 1 -> row_valid=0, row_count=0, overflow=0, row_data=0.
//  2 Stagger: col j valid at cycle 10+j with col_psum[j]=j*256+1, row_ready=0 -> row_valid rises cycle 26
//    (after col 15 write at 25), row_data[j]=j*256+1 for all j, row_count=1.
//  3 Stream: 20 rows, stagger 1, row_ready=1 always -> 20 pops in order, rows match, overflow=0,
//    pointers wrap past DEPTH=8 at least twice.
//  4 Full: row_ready=0, push 9 full rows -> row_count=8, 9th row dropped in every column,
//    overflow=1; then pop 8 rows -> rows 0..7 exact, row_valid=0.
//  5 Backpressure toggle: row_ready random 50% during stream of 12 rows -> no loss, no duplicate,
//    row_data stable whenever row_valid && !row_ready.
//  6 flush mid-row: cols 0..7 written for row 3, then flush -> row_count=0, row_valid=0,
//    overflow unchanged; next full row emerges intact as first output.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions used by the array edge blocks.
package tpu_pkg;

  localparam int SYS_DIM = 16;
  localparam int PSUM_W  = 32;

  typedef logic [PSUM_W-1:0] psum_t;
  typedef psum_t psum_row_t [SYS_DIM];

endpackage

// File: rtl/collector_col_ptr.sv
// Per-column write side of the row collector: write pointer, occupancy
// against the shared read pointer, and the accept/drop decision.
module collector_col_ptr #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          col_valid,
  input  logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] occ,
  output logic          accept,
  output logic          drop
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          full;

  // Occupancy is modulo 2*DEPTH; the wrap bit separates full from empty.
  // A column at DEPTH drops its word even if the head row pops this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    occ      = wr_ptr_q - rd_ptr;
    full     = (occ == PW'(DEPTH));
    accept   = col_valid && !flush && !full;
    drop     = col_valid && !flush && full;
    if (flush) begin
      wr_ptr_d = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  // Write pointer register.
  always_ff @(posedge clk) begin
    // NOTE: flops use <= so every register updates from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_ptr = wr_ptr_q;

endmodule

// File: rtl/systolic_output_collector.sv
// Bottom-edge collector: realigns column-staggered psums into full rows,
// buffers them in a small row FIFO and hands them out on valid/ready.
module systolic_output_collector #(
  parameter  int SYS_DIM = tpu_pkg::SYS_DIM,
  parameter  int PSUM_W  = tpu_pkg::PSUM_W,
  parameter  int DEPTH   = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PSUM_W-1:0]  col_psum [SYS_DIM],
  input  logic [SYS_DIM-1:0] col_valid,
  input  logic               flush,
  output logic [PSUM_W-1:0]  row_data [SYS_DIM],
  output logic               row_valid,
  input  logic               row_ready,
  output logic [PW-1:0]      row_count,
  output logic               overflow
);

  logic [PSUM_W-1:0]  mem_q [DEPTH][SYS_DIM];
  logic [PSUM_W-1:0]  mem_d [DEPTH][SYS_DIM];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [PW-1:0]      wr_ptr [SYS_DIM];
  logic [PW-1:0]      occ    [SYS_DIM];
  logic [SYS_DIM-1:0] accept;
  logic [SYS_DIM-1:0] drop;
  logic [AW-1:0]      head;
  logic               pop;

  for (genvar j = 0; j < SYS_DIM; j++) begin : g_col
    collector_col_ptr #(.DEPTH(DEPTH)) u_col_ptr (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .col_valid (col_valid[j]),
      .rd_ptr    (rd_ptr_q),
      .wr_ptr    (wr_ptr[j]),
      .occ       (occ[j]),
      .accept    (accept[j]),
      .drop      (drop[j])
    );
  end

  // Complete rows = the least-filled column; a pop needs a complete head row.
  always_comb begin
    row_count = occ[0];
    for (int j = 1; j < SYS_DIM; j++) begin
      if (occ[j] < row_count) row_count = occ[j];
    end
    row_valid = (row_count != '0);
    head      = rd_ptr_q[AW-1:0];
    pop       = row_valid && row_ready && !flush;
  end

  // Next-state for storage, read pointer and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (|drop);
    if (flush) begin
      rd_ptr_d = '0;
      for (int d = 0; d < DEPTH; d++) begin
        for (int j = 0; j < SYS_DIM; j++) mem_d[d][j] = '0;
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        for (int j = 0; j < SYS_DIM; j++) mem_d[head][j] = '0;
      end
      // An accepted write never targets the head slot while it pops:
      // that would need occ==DEPTH, which drops the word instead.
      for (int j = 0; j < SYS_DIM; j++) begin
        if (accept[j]) mem_d[wr_ptr[j][AW-1:0]][j] = col_psum[j];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      // NOTE: storage is reset on purpose so an empty head row reads as zero.
      for (int d = 0; d < DEPTH; d++) begin
        for (int j = 0; j < SYS_DIM; j++) mem_q[d][j] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign row_data = mem_q[head];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for the systolic output collector.
module tb_systolic_output_collector;
  import tpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               row_valid;
  logic               row_ready;
  logic               overflow;
  logic [SYS_DIM-1:0] col_valid;
  logic [PW-1:0]      row_count;
  psum_row_t          col_psum;
  psum_row_t          row_data;

  int tests_run    = 0;
  int tests_failed = 0;

  systolic_output_collector #(.SYS_DIM(SYS_DIM), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_psum  (col_psum),
    .col_valid (col_valid),
    .flush     (flush),
    .row_data  (row_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_count (row_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Word for row id in column j; row id 0 gives j*256+1.
  function automatic psum_t word_of(input int id, input int j);
    return psum_t'(id * 65536 + j * 256 + 1);
  endfunction

  task automatic idle_inputs();
    col_valid = '0;
    for (int j = 0; j < SYS_DIM; j++) col_psum[j] = '0;
    row_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams n_drive rows (ids base..) with column j of row r at cycle r*gap+j,
  // pops with the given ready mode (0 never, 1 always, 2 random) until n_expect
  // rows left. Whenever a row is valid its data must equal the next expected row.
  task automatic run_stream(input string tag, input int base, input int n_drive,
                            input int gap, input int mode, input int n_expect);
    int t_end;
    int rx;
    logic rdy;
    t_end = (n_drive == 0) ? 0 : (n_drive - 1) * gap + SYS_DIM;
    rx    = 0;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (t >= t_end && rx >= n_expect) begin
        idle_inputs();
        break;
      end
      if (t > t_end + 400) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s timeout: popped %0d rows, required %0d", tag, rx, n_expect);
        idle_inputs();
        break;
      end
      if (row_valid) begin
        int bad;
        bad = -1;
        for (int j = 0; j < SYS_DIM; j++) begin
          if (bad < 0 && row_data[j] !== word_of(base + rx, j)) bad = j;
        end
        tests_run++;
        if (bad >= 0) begin
          tests_failed++;
          $display("FAIL %s row %0d col %0d: got %h, required %h", tag, rx, bad,
                   row_data[bad], word_of(base + rx, bad));
        end
      end
      case (mode)
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b0;
      endcase
      row_ready = rdy;
      if (row_valid && rdy) rx++;
      for (int j = 0; j < SYS_DIM; j++) begin
        int off;
        off = t - j;
        if (off >= 0 && off % gap == 0 && off / gap < n_drive) begin
          col_valid[j] = 1'b1;
          col_psum[j]  = word_of(base + off / gap, j);
        end else begin
          col_valid[j] = 1'b0;
          col_psum[j]  = '0;
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    flush     = 1'b0;
    row_ready = 1'b1;
    col_valid = '1;
    for (int j = 0; j < SYS_DIM; j++) col_psum[j] = 32'hdead_beef;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (row_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_row_valid: got %b, required 0", row_valid);
    end
    tests_run++;
    if (row_count !== 4'd0) begin
      tests_failed++; $display("FAIL reset_row_count: got %0d, required 0", row_count);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overflow: got %b, required 0", overflow);
    end
    bad = -1;
    for (int j = 0; j < SYS_DIM; j++) if (bad < 0 && row_data[j] !== 32'd0) bad = j;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++; $display("FAIL reset_row_data col %0d: got %h, required 0", bad, row_data[bad]);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_stagger();
    int bad;
    for (int t = 0; t < SYS_DIM; t++) begin
      @(negedge clk);
      if (t == SYS_DIM - 1) begin
        tests_run++;
        if (row_valid !== 1'b0 || row_count !== 4'd0) begin
          tests_failed++;
          $display("FAIL stagger_early: row_valid=%b row_count=%0d, required 0/0", row_valid, row_count);
        end
      end
      col_valid = '0;
      for (int j = 0; j < SYS_DIM; j++) col_psum[j] = '0;
      col_valid[t] = 1'b1;
      col_psum[t]  = word_of(0, t);
    end
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (row_valid !== 1'b1 || row_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL stagger_valid: row_valid=%b row_count=%0d, required 1/1", row_valid, row_count);
    end
    bad = -1;
    for (int j = 0; j < SYS_DIM; j++) if (bad < 0 && row_data[j] !== word_of(0, j)) bad = j;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL stagger_data col %0d: got %h, required %h", bad, row_data[bad], word_of(0, bad));
    end
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    tests_run++;
    if (row_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stagger_pop: row_valid=%b, required 0", row_valid);
    end
  endtask

  task automatic test_stream();
    run_stream("stream", 100, 20, 3, 1, 20);
    tests_run++;
    if (overflow !== 1'b0 || row_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end: overflow=%b row_valid=%b, required 0/0", overflow, row_valid);
    end
  endtask

  task automatic test_full();
    run_stream("full_fill", 200, 9, 1, 0, 0);
    tests_run++;
    if (row_count !== 4'd8 || overflow !== 1'b1 || row_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_state: row_count=%0d overflow=%b row_valid=%b, required 8/1/1",
               row_count, overflow, row_valid);
    end
    run_stream("full_drain", 200, 0, 1, 1, 8);
    tests_run++;
    if (row_valid !== 1'b0 || row_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL full_empty: row_valid=%b row_count=%0d, required 0/0", row_valid, row_count);
    end
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 300, 12, 8, 2, 12);
    tests_run++;
    if (row_valid !== 1'b0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_end: row_valid=%b overflow=%b, required 0/1", row_valid, overflow);
    end
  endtask

  task automatic test_flush();
    int bad;
    // Rows 0..2 complete, row 3 only in columns 0..7.
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      for (int j = 0; j < SYS_DIM; j++) begin
        int r;
        r = t - j;
        if (r >= 0 && r <= 3 && !(r == 3 && j > 7)) begin
          col_valid[j] = 1'b1;
          col_psum[j]  = word_of(600 + r, j);
        end else begin
          col_valid[j] = 1'b0;
          col_psum[j]  = '0;
        end
      end
    end
    @(negedge clk);
    tests_run++;
    if (row_count !== 4'd3) begin
      tests_failed++; $display("FAIL flush_pre_count: got %0d, required 3", row_count);
    end
    // Flush wins over a same-cycle write and pop.
    flush        = 1'b1;
    row_ready    = 1'b1;
    col_valid    = '0;
    col_valid[8] = 1'b1;
    col_psum[8]  = word_of(603, 8);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (row_count !== 4'd0 || row_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_state: row_count=%0d row_valid=%b, required 0/0", row_count, row_valid);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++; $display("FAIL flush_overflow: got %b, required 1", overflow);
    end
    bad = -1;
    for (int j = 0; j < SYS_DIM; j++) if (bad < 0 && row_data[j] !== 32'd0) bad = j;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++; $display("FAIL flush_data col %0d: got %h, required 0", bad, row_data[bad]);
    end
    // Ready with nothing valid must not move the read pointer.
    row_ready = 1'b1;
    repeat (3) @(negedge clk);
    row_ready = 1'b0;
    run_stream("flush_next", 700, 1, 1, 1, 1);
    tests_run++;
    if (row_valid !== 1'b0 || row_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL flush_after: row_valid=%b row_count=%0d, required 0/0", row_valid, row_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_stagger();
    do_reset();
    test_stream();
    test_full();
    test_backpressure();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
